vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Parametrised arbiter that shares one single-port video RAM (iCE40 SPRAM style, 1-cycle read latency) between the VGA pixel fetcher and the CPU memory-mapped screen port. It succeeds the fixed 13-bit/16-bit screen VRAM path with generic address and data widths and a posted-write queue, so CPU writes no longer stall behind pixel fetches. CPU reads forward from the queue on an address hit. It sits inside the screen subsystem, between the VGA timing block, the CPU bus and the RAM macro.

## Interface
Parameters:
- ADDR_W, 13, word address width
- DATA_W, 16, word width
- WQ_DEPTH, 4, write-queue entries (power of two, ≥2)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- p_read  in  1  pixel fetch request; has absolute priority
- p_addr  in  ADDR_W  pixel fetch address
- p_dout  out  DATA_W  pixel data; equals mem_dout
- p_valid  out  1  p_dout valid, cycle after p_read
- s_write  in  1  CPU write strobe, sampled when s_busy low
- s_read  in  1  CPU read strobe, sampled when s_busy low
- s_addr  in  ADDR_W  CPU address
- s_din  in  DATA_W  CPU write data
- s_dout  out  DATA_W  CPU read data, registered, held until next read completes
- s_valid  out  1  one-cycle pulse: s_dout updated
- s_busy  out  1  CPU side cannot accept a request this cycle
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_din  out  DATA_W  RAM write data
- mem_dout  in  DATA_W  RAM read data, 1 cycle after address

## Operation
- Memory slot priority per cycle: p_read > issued CPU read (state R_WAIT) > queue drain (head entry, mem_we=1) > idle (mem_we=0, mem_addr=0).
- s_busy = queue full OR read state ≠ R_IDLE. Combinational.
- s_write accepted (!s_busy) → push {s_addr, s_din} to the tail. Push and drain in the same cycle are both performed.
- s_write and s_read both high while accepted: the write is taken and the read is dropped.
- s_read accepted, queue holds matching address → forward data of the youngest matching entry into s_dout. State stays R_IDLE.
- s_read accepted, no match → latch address, go to R_WAIT.
- Read FSM: R_IDLE → R_WAIT (miss accepted). R_WAIT → R_DATA in the first cycle with p_read low; the RAM read is issued that cycle. R_DATA → R_IDLE, capturing mem_dout into s_dout.
- Ordering: a CPU read waiting in R_WAIT is served before the queue drains. This is safe because a queue hit was already forwarded.
- No fairness guarantee. Continuous p_read starves the CPU side; the VGA block releases p_read during blanking.
- Reset (asynchronous, any state, including mid-read or queue non-empty):
  - queue emptied and pending writes discarded;
  - FSM to R_IDLE;
  - p_valid=0, s_valid=0, s_dout=0, s_busy=0, mem_we=0.

## Timing
- Pixel read: p_read in cycle N → p_valid=1 in N+1, p_dout=mem_dout. Fixed latency, never delayed.
- CPU read, queue hit: accepted N → s_valid in N+1.
- CPU read, miss with free slot: accepted N, issued N+1, s_valid N+3. Each cycle of p_read in R_WAIT adds one cycle.
- CPU write: accepted N → RAM write no earlier than N+1. Drains proceed at one entry per free cycle.
- s_busy deasserts in the cycle the FSM returns to R_IDLE, or in the cycle after a drain takes the queue below full.

## Structure
- Shared package vram_pkg holds:
  - the read-state enum {R_IDLE, R_WAIT, R_DATA};
  - a write-entry struct {addr, data}.
- Sub-module vram_write_queue: circular FIFO with head/tail pointers plus a wrap bit. It provides full/empty flags and a youngest-match lookup (hit, data) over the valid entries.

## Test plan
- Pixel read only: RAM[0x0010]=0xBEEF, p_read with p_addr=0x0010 in cycle 5 → p_valid and p_dout=0xBEEF in cycle 6; s_busy stays 0.
- Posted writes and full: p_read held high, four s_writes to 0x0100..0x0103 → accepted, s_busy=1 after the fourth. Release p_read → four consecutive mem_we cycles in order, then s_busy=0.
- Forwarding: s_write 0x0200=0x1111, then 0x0200=0x2222, then s_read 0x0200 while p_read is high → s_valid next cycle with s_dout=0x2222 (youngest match).
- Read miss under contention: RAM[0x0300]=0xA5A5, s_read 0x0300 with p_read high for 3 more cycles → s_valid exactly 3 cycles later than the uncontended case, s_dout=0xA5A5; p_valid is unaffected throughout.
- Simultaneous strobes: s_write and s_read in the same cycle to 0x0400, data 0x7777 → write queued, no s_valid; RAM[0x0400]=0x7777 after drain.
- Reset mid-operation: queue holds 2 entries and FSM is in R_WAIT, assert reset → outputs at reset values immediately. After release, no mem_we for the discarded entries and s_busy=0.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: read-side FSM states and the default
// posted-write entry layout (13-bit word address, 16-bit word).
package vram_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rd_state_t;

  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 16;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/vram_write_queue.sv
// Circular posted-write FIFO (head/tail pointers with a wrap bit) with a
// youngest-match address lookup over the valid entries.
module vram_write_queue
  import vram_pkg::*;
#(
  parameter int  ADDR_W  = VRAM_ADDR_W,
  parameter int  DATA_W  = VRAM_DATA_W,
  parameter int  DEPTH   = 4,
  parameter type entry_t = wq_entry_t
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  entry_t            i_push_ent,
  input  logic              i_pop,
  output entry_t            o_head,
  output logic              o_full,
  output logic              o_empty,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_hit_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          r_mem [DEPTH];
  logic [PW:0]     r_head;
  logic [PW:0]     r_tail;
  logic [PW:0]     w_count;

  assign w_count = r_tail - r_head;
  assign o_empty = (r_head == r_tail);
  assign o_full  = (r_head[PW] != r_tail[PW]) && (r_head[PW-1:0] == r_tail[PW-1:0]);
  assign o_head  = r_mem[r_head[PW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (i_push && !o_full) r_tail <= r_tail + 1'b1;
      if (i_pop && !o_empty) r_head <= r_head + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !o_full) r_mem[r_tail[PW-1:0]] <= i_push_ent;
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < w_count) &&
          (r_mem[PW'(r_head[PW-1:0] + PW'(k))].addr == i_lookup_addr)) begin
        o_hit      = 1'b1;
        o_hit_data = r_mem[PW'(r_head[PW-1:0] + PW'(k))].data;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: pixel fetches win every slot, CPU writes are
// posted into a small queue, CPU reads forward from the queue or go to RAM.
//
// state  | meaning
// R_IDLE | no CPU read outstanding; reads may be accepted
// R_WAIT | miss latched, waiting for a slot without p_read
// R_DATA | RAM read issued last cycle; capture mem_dout
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 16,
  parameter int WQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_read,
  input  logic [ADDR_W-1:0] p_addr,
  output logic [DATA_W-1:0] p_dout,
  output logic              p_valid,
  input  logic              s_write,
  input  logic              s_read,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              s_valid,
  output logic              s_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_p_valid;
  logic              r_s_valid;
  logic [DATA_W-1:0] r_s_dout;

  entry_t            w_push_ent;
  entry_t            w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_hit;
  logic [DATA_W-1:0] w_hit_data;
  logic              w_busy;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_drain;

  assign w_busy     = w_full || (r_state != R_IDLE);
  assign w_wr_acc   = s_write && !w_busy;
  assign w_rd_acc   = s_read && !s_write && !w_busy;
  // A waiting CPU read takes the slot ahead of the queue; any queued data
  // for that address would already have been forwarded.
  assign w_drain    = !p_read && (r_state != R_WAIT) && !w_empty;
  assign w_push_ent = '{addr: s_addr, data: s_din};

  vram_write_queue #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (WQ_DEPTH),
    .entry_t (entry_t)
  ) u_wq (
    .clk           (clk),
    .reset         (reset),
    .i_push        (w_wr_acc),
    .i_push_ent    (w_push_ent),
    .i_pop         (w_drain),
    .o_head        (w_head),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .i_lookup_addr (s_addr),
    .o_hit         (w_hit),
    .o_hit_data    (w_hit_data)
  );

  always_comb begin
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_din  = '0;
    if (p_read) begin
      mem_addr = p_addr;
    end else if (r_state == R_WAIT) begin
      mem_addr = r_rd_addr;
    end else if (w_drain) begin
      mem_addr = w_head.addr;
      mem_din  = w_head.data;
      mem_we   = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (w_rd_acc && !w_hit) w_state_nxt = R_WAIT;
      R_WAIT:  if (!p_read) w_state_nxt = R_DATA;
      R_DATA:  w_state_nxt = R_IDLE;
      default: w_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= R_IDLE;
      r_rd_addr <= '0;
      r_p_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_s_dout  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_p_valid <= p_read;
      r_s_valid <= 1'b0;
      if (w_rd_acc) begin
        if (w_hit) begin
          r_s_dout  <= w_hit_data;
          r_s_valid <= 1'b1;
        end else begin
          r_rd_addr <= s_addr;
        end
      end
      if (r_state == R_DATA) begin
        r_s_dout  <= mem_dout;
        r_s_valid <= 1'b1;
      end
    end
  end

  assign p_dout  = mem_dout;
  assign p_valid = r_p_valid;
  assign s_dout  = r_s_dout;
  assign s_valid = r_s_valid;
  assign s_busy  = w_busy;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed stimulus pushes expected pixel,
// CPU-read and RAM-write events; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_read;
  logic [12:0] p_addr;
  logic [15:0] p_dout;
  logic        p_valid;
  logic        s_write;
  logic        s_read;
  logic [12:0] s_addr;
  logic [15:0] s_din;
  logic [15:0] s_dout;
  logic        s_valid;
  logic        s_busy;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  logic [15:0] ram [0:8191];
  logic        tb_we = 1'b0;
  logic [12:0] tb_addr = '0;
  logic [15:0] tb_data = '0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int c;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } rd_exp_t;

  typedef struct {
    logic [12:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_exp_t;

  rd_exp_t p_q[$];
  rd_exp_t s_q[$];
  wr_exp_t w_q[$];
  rd_exp_t pe;
  rd_exp_t se;
  wr_exp_t we_e;

  vram_arbiter #(.ADDR_W(13), .DATA_W(16), .WQ_DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .p_read   (p_read),
    .p_addr   (p_addr),
    .p_dout   (p_dout),
    .p_valid  (p_valid),
    .s_write  (s_write),
    .s_read   (s_read),
    .s_addr   (s_addr),
    .s_din    (s_din),
    .s_dout   (s_dout),
    .s_valid  (s_valid),
    .s_busy   (s_busy),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (tb_we) ram[tb_addr] <= tb_data;
    else if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (p_valid) begin
      if (p_q.size() == 0) check("p_valid_unexpected", 32'(p_valid), 32'(0));
      else begin
        pe = p_q.pop_front();
        check("p_dout", 32'(p_dout), 32'(pe.data));
        check("p_valid_cycle", cyc, pe.cyc);
      end
    end
    if (s_valid) begin
      if (s_q.size() == 0) check("s_valid_unexpected", 32'(s_valid), 32'(0));
      else begin
        se = s_q.pop_front();
        check("s_dout", 32'(s_dout), 32'(se.data));
        check("s_valid_cycle", cyc, se.cyc);
      end
    end
    if (mem_we) begin
      if (w_q.size() == 0) check("mem_we_unexpected", 32'(mem_we), 32'(0));
      else begin
        we_e = w_q.pop_front();
        check("mem_addr", 32'(mem_addr), 32'(we_e.addr));
        check("mem_din", 32'(mem_din), 32'(we_e.data));
        check("mem_we_cycle", cyc, we_e.cyc);
      end
    end
  end

  task automatic step(input bit pr, input logic [12:0] pa, input logic [15:0] pexp, input bit pchk,
                      input bit sw, input bit sr, input logic [12:0] sa, input logic [15:0] sd);
    p_read  = pr;
    p_addr  = pa;
    s_write = sw;
    s_read  = sr;
    s_addr  = sa;
    s_din   = sd;
    if (pr && pchk) p_q.push_back('{pexp, cyc + 1});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 1'b0, 13'h0, 16'h0);
  endtask

  // CPU stimulus while the pixel fetcher reads 0x0010 (always 0xBEEF).
  task automatic pstep(input bit sw, input bit sr, input logic [12:0] sa, input logic [15:0] sd);
    step(1'b1, 13'h0010, 16'hBEEF, 1'b1, sw, sr, sa, sd);
  endtask

  task automatic preload(input logic [12:0] a, input logic [15:0] d);
    tb_we   = 1'b1;
    tb_addr = a;
    tb_data = d;
    @(posedge clk);
    #1;
    tb_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    p_read  = 1'b0;
    p_addr  = '0;
    s_write = 1'b0;
    s_read  = 1'b0;
    s_addr  = '0;
    s_din   = '0;
    preload(13'h0010, 16'hBEEF);
    preload(13'h0300, 16'hA5A5);
    check("rst_p_valid", 32'(p_valid), 32'(0));
    check("rst_s_valid", 32'(s_valid), 32'(0));
    check("rst_s_dout", 32'(s_dout), 32'(0));
    check("rst_s_busy", 32'(s_busy), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    reset = 1'b0;
    idle(3);

    // Pixel read only
    check("t1_busy_pre", 32'(s_busy), 32'(0));
    step(1'b1, 13'h0010, 16'hBEEF, 1'b1, 1'b0, 1'b0, 13'h0, 16'h0);
    check("t1_busy_post", 32'(s_busy), 32'(0));
    idle(2);

    // Posted writes fill the queue under continuous pixel reads
    for (int i = 0; i < 4; i++) begin
      check("t2_busy_accept", 32'(s_busy), 32'(0));
      pstep(1'b1, 1'b0, 13'(13'h0100 + i), 16'(16'hC000 + i));
    end
    check("t2_busy_full", 32'(s_busy), 32'(1));
    c = cyc;
    for (int i = 0; i < 4; i++) w_q.push_back('{13'(13'h0100 + i), 16'(16'hC000 + i), c + i});
    idle(1);
    check("t2_busy_release", 32'(s_busy), 32'(0));
    idle(5);

    // Forwarding returns the youngest matching entry
    pstep(1'b1, 1'b0, 13'h0200, 16'h1111);
    pstep(1'b1, 1'b0, 13'h0200, 16'h2222);
    check("t3_busy_pre", 32'(s_busy), 32'(0));
    s_q.push_back('{16'h2222, cyc + 1});
    pstep(1'b0, 1'b1, 13'h0200, 16'h0);
    c = cyc;
    check("t3_busy_hit_idle", 32'(s_busy), 32'(0));
    w_q.push_back('{13'h0200, 16'h1111, c});
    w_q.push_back('{13'h0200, 16'h2222, c + 1});
    idle(4);

    // Read miss, uncontended then contended by three extra p_read cycles
    s_q.push_back('{16'hA5A5, cyc + 3});
    step(1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 1'b1, 13'h0300, 16'h0);
    check("t4_busy_wait", 32'(s_busy), 32'(1));
    idle(1);
    check("t4_busy_data", 32'(s_busy), 32'(1));
    idle(1);
    check("t4_busy_done", 32'(s_busy), 32'(0));
    idle(2);
    s_q.push_back('{16'hA5A5, cyc + 6});
    pstep(1'b0, 1'b1, 13'h0300, 16'h0);
    for (int i = 0; i < 3; i++) pstep(1'b0, 1'b0, 13'h0, 16'h0);
    check("t4_busy_contended", 32'(s_busy), 32'(1));
    idle(6);

    // Simultaneous strobes: write wins, read dropped
    check("t5_busy_pre", 32'(s_busy), 32'(0));
    c = cyc;
    w_q.push_back('{13'h0400, 16'h7777, c + 1});
    step(1'b0, 13'h0, 16'h0, 1'b0, 1'b1, 1'b1, 13'h0400, 16'h7777);
    check("t5_state_idle", 32'(s_busy), 32'(0));
    idle(1);
    step(1'b1, 13'h0400, 16'h7777, 1'b1, 1'b0, 1'b0, 13'h0, 16'h0);
    s_q.push_back('{16'h7777, cyc + 3});
    step(1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 1'b1, 13'h0400, 16'h0);
    idle(4);

    // Reset with two queued writes and a read waiting
    pstep(1'b1, 1'b0, 13'h0500, 16'h5050);
    pstep(1'b1, 1'b0, 13'h0501, 16'h5151);
    step(1'b1, 13'h0010, 16'h0, 1'b0, 1'b0, 1'b1, 13'h0600, 16'h0);
    check("t6_busy_pre", 32'(s_busy), 32'(1));
    p_read = 1'b0;
    s_read = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("t6_p_valid", 32'(p_valid), 32'(0));
    check("t6_s_valid", 32'(s_valid), 32'(0));
    check("t6_s_dout", 32'(s_dout), 32'(0));
    check("t6_s_busy", 32'(s_busy), 32'(0));
    check("t6_mem_we", 32'(mem_we), 32'(0));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t6_busy_release", 32'(s_busy), 32'(0));
    idle(6);
    check("t6_busy_after", 32'(s_busy), 32'(0));

    check("p_q_left", p_q.size(), 0);
    check("s_q_left", s_q.size(), 0);
    check("w_q_left", w_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
